// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: resolves taken branches, stack returns and
// interrupt entry into PC loads, using a handshaked data-memory port
// for the return-address pop and the interrupt push.
module pc_redirect_ctrl #(
    parameter logic [7:0]  IRQ_VECTOR  = 8'h01,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       b_take_i,
    input  logic [1:0] pc_src_i,
    input  logic [7:0] br_target_i,
    input  logic [7:0] pc_ret_i,
    input  logic       is_rti_i,
    input  logic       irq_i,
    input  logic       mem_ack_i,
    input  logic [7:0] mem_rdata_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic [7:0] mem_wdata_o,
    output logic       pc_load_o,
    output logic [7:0] pc_next_o,
    output logic       flush_o,
    output logic       stall_o,
    output logic       irq_ack_o,
    output logic       mem_err_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_RET_WAIT = 2'b01,
        S_IRQ_PUSH = 2'b10
    } state_t;

    // Last wait cycle index; an un-acked cycle at this count aborts.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       in_isr_q, in_isr_d;
    logic       ret_rti_q, ret_rti_d;
    logic [7:0] saved_pc_q, saved_pc_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    logic       mem_req_c, mem_we_c, pc_load_c, flush_c, stall_c;
    logic       irq_ack_c, mem_err_c;
    logic [7:0] mem_wdata_c, pc_next_c;

    logic br_fw, br_ret, tmo_hit;

    // pc_src=11 decodes to neither redirect, so it behaves as NORM.
    assign br_fw   = b_take_i && (pc_src_i == 2'b01);
    assign br_ret  = b_take_i && (pc_src_i == 2'b10);
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    // Next-state and same-cycle output decode.
    always_comb begin
        state_d     = state_q;
        in_isr_d    = in_isr_q;
        ret_rti_d   = ret_rti_q;
        saved_pc_d  = saved_pc_q;
        tmo_cnt_d   = tmo_cnt_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_wdata_c = 8'h00;
        pc_load_c   = 1'b0;
        pc_next_c   = 8'h00;
        flush_c     = 1'b0;
        stall_c     = 1'b0;
        irq_ack_c   = 1'b0;
        mem_err_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (br_fw) begin
                    pc_load_c = 1'b1;
                    pc_next_c = br_target_i;
                    flush_c   = 1'b1;
                end else if (br_ret) begin
                    flush_c   = 1'b1;
                    ret_rti_d = is_rti_i;
                    tmo_cnt_d = 8'h00;
                    state_d   = S_RET_WAIT;
                end else if (irq_i && !in_isr_q) begin
                    // Branches win; a still-pending irq is taken once IDLE is quiet.
                    irq_ack_c  = 1'b1;
                    flush_c    = 1'b1;
                    saved_pc_d = pc_ret_i;
                    in_isr_d   = 1'b1;
                    tmo_cnt_d  = 8'h00;
                    state_d    = S_IRQ_PUSH;
                end
            end
            S_RET_WAIT: begin
                mem_req_c = 1'b1;
                stall_c   = 1'b1;
                if (mem_ack_i) begin
                    // An ack on the timeout cycle still completes normally.
                    pc_load_c = 1'b1;
                    pc_next_c = mem_rdata_i;
                    if (ret_rti_q) begin
                        in_isr_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    mem_err_c = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_IRQ_PUSH: begin
                mem_req_c   = 1'b1;
                mem_we_c    = 1'b1;
                mem_wdata_c = saved_pc_q;
                stall_c     = 1'b1;
                if (mem_ack_i) begin
                    pc_load_c = 1'b1;
                    pc_next_c = IRQ_VECTOR;
                    state_d   = S_IDLE;
                end else if (tmo_hit) begin
                    // in_isr stays set: the handler context is considered entered.
                    mem_err_c = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_isr_q   <= 1'b0;
            ret_rti_q  <= 1'b0;
            saved_pc_q <= 8'h00;
            tmo_cnt_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            in_isr_q   <= in_isr_d;
            ret_rti_q  <= ret_rti_d;
            saved_pc_q <= saved_pc_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted, even when inputs
    // would otherwise produce a combinational redirect.
    assign mem_req_o   = rst_n & mem_req_c;
    assign mem_we_o    = rst_n & mem_we_c;
    assign mem_wdata_o = rst_n ? mem_wdata_c : 8'h00;
    assign pc_load_o   = rst_n & pc_load_c;
    assign pc_next_o   = rst_n ? pc_next_c : 8'h00;
    assign flush_o     = rst_n & flush_c;
    assign stall_o     = rst_n & stall_c;
    assign irq_ack_o   = rst_n & irq_ack_c;
    assign mem_err_o   = rst_n & mem_err_c;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed testbench for pc_redirect_ctrl: inputs change just after the
// falling edge and outputs are checked 1 ns later, well before the rising edge.
module tb_pc_redirect_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       b_take_i;
    logic [1:0] pc_src_i;
    logic [7:0] br_target_i;
    logic [7:0] pc_ret_i;
    logic       is_rti_i;
    logic       irq_i;
    logic       mem_ack_i;
    logic [7:0] mem_rdata_i;
    logic       mem_req_o;
    logic       mem_we_o;
    logic [7:0] mem_wdata_o;
    logic       pc_load_o;
    logic [7:0] pc_next_o;
    logic       flush_o;
    logic       stall_o;
    logic       irq_ack_o;
    logic       mem_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    pc_redirect_ctrl #(.IRQ_VECTOR(8'h01), .MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .b_take_i    (b_take_i),
        .pc_src_i    (pc_src_i),
        .br_target_i (br_target_i),
        .pc_ret_i    (pc_ret_i),
        .is_rti_i    (is_rti_i),
        .irq_i       (irq_i),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .pc_load_o   (pc_load_o),
        .pc_next_o   (pc_next_o),
        .flush_o     (flush_o),
        .stall_o     (stall_o),
        .irq_ack_o   (irq_ack_o),
        .mem_err_o   (mem_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    // Advance to the next falling edge, apply inputs, let logic settle.
    task automatic cyc(input logic b, input logic [1:0] src, input logic [7:0] tgt,
                       input logic rti, input logic ir, input logic ack, input logic [7:0] rd);
        @(negedge clk);
        b_take_i    = b;
        pc_src_i    = src;
        br_target_i = tgt;
        is_rti_i    = rti;
        irq_i       = ir;
        mem_ack_i   = ack;
        mem_rdata_i = rd;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        b_take_i = 1'b1; pc_src_i = 2'b01; br_target_i = 8'h3C;
        pc_ret_i = 8'h20; is_rti_i = 1'b0; irq_i = 1'b1;
        mem_ack_i = 1'b0; mem_rdata_i = 8'h00;
        #2;
        // Reset masks even a combinational redirect request.
        chk("rst_pc_load", 8'(pc_load_o), 8'h00);
        chk("rst_pc_next", pc_next_o, 8'h00);
        chk("rst_flush", 8'(flush_o), 8'h00);
        chk("rst_irq_ack", 8'(irq_ack_o), 8'h00);

        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;

        // First redirect after reset release, same cycle.
        cyc(1'b1, 2'b01, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fw_pc_load", 8'(pc_load_o), 8'h01);
        chk("fw_pc_next", pc_next_o, 8'h3C);
        chk("fw_flush", 8'(flush_o), 8'h01);
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fw_stay_idle_stall", 8'(stall_o), 8'h00);
        chk("idle_pc_next", pc_next_o, 8'h00);

        // Stack return: flush, 3 stall cycles, load 5A on ack.
        cyc(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ret_flush", 8'(flush_o), 8'h01);
        chk("ret_no_load", 8'(pc_load_o), 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
            chk("ret_wait_stall", 8'(stall_o), 8'h01);
            chk("ret_wait_req", 8'(mem_req_o), 8'h01);
            chk("ret_wait_we", 8'(mem_we_o), 8'h00);
            chk("ret_wait_no_load", 8'(pc_load_o), 8'h00);
        end
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A);
        chk("ret_ack_load", 8'(pc_load_o), 8'h01);
        chk("ret_ack_next", pc_next_o, 8'h5A);
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ret_back_idle_req", 8'(mem_req_o), 8'h00);

        // Illegal source with b_take behaves as NORM.
        cyc(1'b1, 2'b11, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ill_no_load", 8'(pc_load_o), 8'h00);
        chk("ill_no_flush", 8'(flush_o), 8'h00);

        // irq coincident with forward branch: branch first, irq next cycle.
        pc_ret_i = 8'h20;
        cyc(1'b1, 2'b01, 8'h44, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("coin_br_load", 8'(pc_load_o), 8'h01);
        chk("coin_br_next", pc_next_o, 8'h44);
        chk("coin_no_ack", 8'(irq_ack_o), 8'h00);
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("irq_ack", 8'(irq_ack_o), 8'h01);
        chk("irq_flush", 8'(flush_o), 8'h01);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
            chk("push_we", 8'(mem_we_o), 8'h01);
            chk("push_wdata", mem_wdata_o, 8'h20);
            chk("push_stall", 8'(stall_o), 8'h01);
            chk("push_no_reack", 8'(irq_ack_o), 8'h00);
        end
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("push_ack_load", 8'(pc_load_o), 8'h01);
        chk("push_ack_vec", pc_next_o, 8'h01);
        // In ISR: irq blocked; stray ack in IDLE ignored.
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hEE);
        chk("isr_irq_blocked", 8'(irq_ack_o), 8'h00);
        chk("idle_ack_ignored", 8'(pc_load_o), 8'h00);
        chk("idle_wdata_zero", mem_wdata_o, 8'h00);

        // RTI with irq pending: return first, then irq accepted again.
        cyc(1'b1, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("rti_flush", 8'(flush_o), 8'h01);
        chk("rti_no_irq_ack", 8'(irq_ack_o), 8'h00);
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h21);
        chk("rti_load_next", pc_next_o, 8'h21);
        pc_ret_i = 8'h30;
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("post_rti_irq_ack", 8'(irq_ack_o), 8'h01);

        // Asynchronous reset in the middle of IRQ_PUSH.
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("push2_wdata", mem_wdata_o, 8'h30);
        #1;
        rst_n = 1'b0;
        mem_ack_i = 1'b1;
        #1;
        chk("arst_mem_req", 8'(mem_req_o), 8'h00);
        chk("arst_stall", 8'(stall_o), 8'h00);
        chk("arst_wdata", mem_wdata_o, 8'h00);
        chk("arst_pc_load", 8'(pc_load_o), 8'h00);
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("arst_aborted_no_load", 8'(pc_load_o), 8'h00);
        chk("arst_aborted_no_stall", 8'(stall_o), 8'h00);
        pc_ret_i = 8'h40;
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("arst_new_irq_ack", 8'(irq_ack_o), 8'h01);
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("push3_vec", pc_next_o, 8'h01);

        // Return timeout: 14 quiet wait cycles, error on the 15th.
        cyc(1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
            chk("tmo_wait_no_err", 8'(mem_err_o), 8'h00);
            chk("tmo_wait_stall", 8'(stall_o), 8'h01);
        end
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("tmo_err", 8'(mem_err_o), 8'h01);
        chk("tmo_no_load", 8'(pc_load_o), 8'h00);
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("tmo_idle_stall", 8'(stall_o), 8'h00);
        chk("tmo_isr_kept", 8'(irq_ack_o), 8'h00);

        // Ack on the timeout cycle wins.
        cyc(1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77);
        chk("tmo_ack_load", 8'(pc_load_o), 8'h01);
        chk("tmo_ack_next", pc_next_o, 8'h77);
        chk("tmo_ack_no_err", 8'(mem_err_o), 8'h00);
        cyc(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("tmo_ack_rti_irq", 8'(irq_ack_o), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
